// File: rtl/ctrl_pkg.sv
// ============================================================
// ctrl_pkg: RV32I opcodes, ALU/result encodings and the ID/EX control bundle
// Revision: 1.0
// ============================================================
`default_nettype none

package ctrl_pkg;

  localparam int unsigned c_ALU_W = 4;

  localparam logic [6:0] c_OPC_OP     = 7'h33;
  localparam logic [6:0] c_OPC_OP_IMM = 7'h13;
  localparam logic [6:0] c_OPC_LOAD   = 7'h03;
  localparam logic [6:0] c_OPC_STORE  = 7'h23;
  localparam logic [6:0] c_OPC_BRANCH = 7'h63;
  localparam logic [6:0] c_OPC_JAL    = 7'h6F;
  localparam logic [6:0] c_OPC_JALR   = 7'h67;
  localparam logic [6:0] c_OPC_LUI    = 7'h37;
  localparam logic [6:0] c_OPC_AUIPC  = 7'h17;

  typedef enum logic [c_ALU_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    alu_op_e     alu_ctrl;
    logic        alu_src;
    logic        alu_a_pc;
    result_src_e result_src;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  branch_cond;
    logic        illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers mask it for encodings where it must be ignored
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================
// instr_decoder: combinational RV32I word -> control bundle, immediate, indices
// Revision: 1.0
// ============================================================
`default_nettype none

module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm32;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign alt   = instr_i[30];
  assign rd_o  = instr_i[11:7];
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];
  assign imm_o = XLEN'($signed(imm32));

  always_comb begin
    ctrl_o     = '0;
    imm32      = '0;
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    case (opc)
      c_OPC_OP: begin
        ctrl_o.alu_ctrl  = alu_from_funct3(f3, alt);
        ctrl_o.reg_write = 1'b1;
        uses_rs2_o       = 1'b1;
      end
      c_OPC_OP_IMM: begin
        ctrl_o.alu_ctrl  = alu_from_funct3(f3, alt & (f3 == 3'b101));
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        imm32            = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      c_OPC_LOAD: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_size   = f3;
        imm32             = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      c_OPC_STORE: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.mem_size  = f3;
        uses_rs2_o       = 1'b1;
        imm32            = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      c_OPC_BRANCH: begin
        uses_rs2_o = 1'b1;
        if (f3[2:1] == 2'b01) begin
          ctrl_o.illegal = 1'b1;
        end else begin
          ctrl_o.alu_ctrl    = ALU_SUB;
          ctrl_o.branch      = 1'b1;
          ctrl_o.branch_cond = f3;
          imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
        end
      end
      c_OPC_JAL: begin
        uses_rs1_o        = 1'b0;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_a_pc   = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      c_OPC_JALR: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.jalr       = 1'b1;
        imm32             = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      c_OPC_LUI: begin
        uses_rs1_o       = 1'b0;
        ctrl_o.alu_ctrl  = ALU_PASS_B;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        imm32            = {instr_i[31:12], 12'b0};
      end
      c_OPC_AUIPC: begin
        uses_rs1_o       = 1'b0;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_a_pc  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        imm32            = {instr_i[31:12], 12'b0};
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
    // x0 is hardwired; never let a write to it leave the stage
    if (instr_i[11:7] == 5'd0) ctrl_o.reg_write = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/decode_ctrl_stage.sv
// ============================================================
// decode_ctrl_stage: ID/EX pipeline register with valid/ready, load-use bubbles, flush
// Revision: 1.0
// ============================================================
`default_nettype none

module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ALUCTRL_W      = 4,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  input  logic [XLEN-1:0]      id_pc,
  output logic                 id_ready,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [ALUCTRL_W-1:0] ex_alu_ctrl,
  output logic                 ex_alu_src,
  output logic                 ex_alu_a_pc,
  output logic [1:0]           ex_result_src,
  output logic                 ex_reg_write,
  output logic                 ex_mem_write,
  output logic                 ex_mem_read,
  output logic [2:0]           ex_mem_size,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic                 ex_jalr,
  output logic [2:0]           ex_branch_cond,
  output logic                 ex_illegal,
  output logic                 hazard_stall
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic            dec_uses_rs1, dec_uses_rs2;

  instr_decoder #(.XLEN(XLEN)) u_dec (
    .instr_i    (id_instr),
    .ctrl_o     (dec_ctrl),
    .imm_o      (dec_imm),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .rd_o       (dec_rd),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2)
  );

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            advance, hazard;

  assign advance = !valid_q || ex_ready;

  // The load in EX has not produced data yet; a dependent word must wait one cycle
  assign hazard = (LOAD_USE_STALL != 0) && valid_q && ctrl_q.mem_read && (rd_q != 5'd0)
                  && id_valid
                  && ((dec_uses_rs1 && (dec_rs1 == rd_q)) || (dec_uses_rs2 && (dec_rs2 == rd_q)));

  assign id_ready     = flush || (advance && !hazard);
  assign hazard_stall = hazard && advance && !flush;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      if (hazard) begin
        valid_d = 1'b0;
      end else begin
        valid_d = id_valid;
        ctrl_d  = dec_ctrl;
        pc_d    = id_pc;
        imm_d   = dec_imm;
        rs1_d   = dec_rs1;
        rs2_d   = dec_rs2;
        rd_d    = dec_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_pc          = pc_q;
  assign ex_imm         = imm_q;
  assign ex_rs1         = rs1_q;
  assign ex_rs2         = rs2_q;
  assign ex_rd          = rd_q;
  assign ex_alu_ctrl    = ALUCTRL_W'(ctrl_q.alu_ctrl);
  assign ex_alu_src     = ctrl_q.alu_src;
  assign ex_alu_a_pc    = ctrl_q.alu_a_pc;
  assign ex_result_src  = ctrl_q.result_src;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_size    = ctrl_q.mem_size;
  assign ex_branch      = ctrl_q.branch;
  assign ex_jump        = ctrl_q.jump;
  assign ex_jalr        = ctrl_q.jalr;
  assign ex_branch_cond = ctrl_q.branch_cond;
  assign ex_illegal     = ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
// ============================================================
// tb_decode_ctrl_stage: random + directed stimulus against an instruction-level model
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic [31:0] id_instr = '0, id_pc = '0;
  logic        id_ready, ex_valid, ex_alu_src, ex_alu_a_pc, ex_reg_write, ex_mem_write;
  logic        ex_mem_read, ex_branch, ex_jump, ex_jalr, ex_illegal, hazard_stall;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_ctrl;
  logic [1:0]  ex_result_src;
  logic [2:0]  ex_mem_size, ex_branch_cond;

  decode_ctrl_stage #(.XLEN(32), .ALUCTRL_W(4), .LOAD_USE_STALL(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src), .ex_alu_a_pc(ex_alu_a_pc),
    .ex_result_src(ex_result_src), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_mem_size(ex_mem_size), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_branch_cond(ex_branch_cond),
    .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        legal, has_imm, chk_src, writes_rd;
    bit [31:0] imm;
    bit [3:0]  alu;
    bit        alu_src, alu_a_pc;
    bit [1:0]  res;
    bit        rw, mw, mr, br, jmp, jalr;
    bit [2:0]  msize, bcond;
  } exp_t;

  function automatic bit uses1(logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction

  function automatic bit uses2(logic [6:0] op);
    return (op == 7'h33 || op == 7'h23 || op == 7'h63);
  endfunction

  // Instruction-level meaning of a word, written from the ISA tables
  function automatic exp_t model_decode(logic [31:0] ins);
    exp_t        e;
    int          v;
    logic [6:0]  op;
    logic [2:0]  f3;
    int unsigned alu_tab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    e = '{default: 0};
    op = ins[6:0];
    f3 = ins[14:12];
    e.legal = 1; e.chk_src = 1; e.has_imm = 1; e.writes_rd = 1;
    case (op)
      7'h33: begin
        e.alu = 4'(alu_tab[f3] + (((f3 == 0 || f3 == 5) && ins[30]) ? 1 : 0));
        e.rw = 1; e.has_imm = 0;
      end
      7'h13: begin
        e.alu = 4'(alu_tab[f3] + ((f3 == 5 && ins[30]) ? 1 : 0));
        e.alu_src = 1; e.rw = 1; v = $signed(ins[31:20]); e.imm = v;
      end
      7'h03: begin
        e.alu_src = 1; e.res = 1; e.rw = 1; e.mr = 1; e.msize = f3;
        v = $signed(ins[31:20]); e.imm = v;
      end
      7'h23: begin
        e.alu_src = 1; e.mw = 1; e.msize = f3; e.writes_rd = 0;
        v = $signed({ins[31:25], ins[11:7]}); e.imm = v;
      end
      7'h63: begin
        e.writes_rd = 0;
        if (f3 == 2 || f3 == 3) e.legal = 0;
        else begin
          e.alu = 1; e.br = 1; e.bcond = f3;
          v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2; e.imm = v;
        end
      end
      7'h6F: begin
        e.res = 2; e.rw = 1; e.jmp = 1; e.chk_src = 0;
        v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; e.imm = v;
      end
      7'h67: begin
        e.alu_src = 1; e.res = 2; e.rw = 1; e.jmp = 1; e.jalr = 1;
        v = $signed(ins[31:20]); e.imm = v;
      end
      7'h37: begin e.alu = 10; e.alu_src = 1; e.rw = 1; e.imm = ins & 32'hFFFF_F000; end
      7'h17: begin e.alu_src = 1; e.alu_a_pc = 1; e.rw = 1; e.imm = ins & 32'hFFFF_F000; end
      default: e.legal = 0;
    endcase
    if (ins[11:7] == 0) e.rw = 0;
    if (!e.legal) begin
      e.rw = 0; e.mw = 0; e.mr = 0; e.br = 0; e.jmp = 0; e.jalr = 0;
    end
    return e;
  endfunction

  // Model of what sits in EX
  bit          m_valid = 0;
  logic [31:0] m_instr = '0, m_pc = '0;

  function automatic bit model_hazard();
    logic [4:0] lrd;
    lrd = m_instr[11:7];
    if (!(m_valid && m_instr[6:0] == 7'h03 && lrd != 0 && id_valid)) return 0;
    return (uses1(id_instr[6:0]) && id_instr[19:15] == lrd) ||
           (uses2(id_instr[6:0]) && id_instr[24:20] == lrd);
  endfunction

  task automatic compare_model();
    exp_t e;
    bit   adv, hz;
    adv = !m_valid || ex_ready;
    hz  = model_hazard();
    chk("id_ready", 32'(id_ready), 32'(flush || (adv && !hz)));
    chk("hazard_stall", 32'(hazard_stall), 32'(hz && adv && !flush));
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    if (m_valid) begin
      e = model_decode(m_instr);
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_illegal", 32'(ex_illegal), 32'(!e.legal));
      chk("enables", 32'({ex_reg_write, ex_mem_write, ex_mem_read, ex_branch, ex_jump, ex_jalr}),
          32'({e.rw, e.mw, e.mr, e.br, e.jmp, e.jalr}));
      if (uses1(m_instr[6:0])) chk("ex_rs1", 32'(ex_rs1), 32'(m_instr[19:15]));
      if (uses2(m_instr[6:0])) chk("ex_rs2", 32'(ex_rs2), 32'(m_instr[24:20]));
      if (e.legal) begin
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(e.alu));
        chk("ex_result_src", 32'(ex_result_src), 32'(e.res));
        if (e.chk_src) chk("alu_src/a_pc", 32'({ex_alu_src, ex_alu_a_pc}), 32'({e.alu_src, e.alu_a_pc}));
        if (e.has_imm) chk("ex_imm", ex_imm, e.imm);
        if (e.writes_rd) chk("ex_rd", 32'(ex_rd), 32'(m_instr[11:7]));
        if (e.mr || e.mw) chk("ex_mem_size", 32'(ex_mem_size), 32'(e.msize));
        if (e.br) chk("ex_branch_cond", 32'(ex_branch_cond), 32'(e.bcond));
      end
    end
  endtask

  task automatic apply(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    @(negedge clk);
    id_valid = v; id_instr = ins; id_pc = pc; ex_ready = rdy; flush = fl;
    #1;
    compare_model();
  endtask

  task automatic tick();
    bit          n_valid;
    logic [31:0] n_instr, n_pc;
    n_valid = m_valid; n_instr = m_instr; n_pc = m_pc;
    if (flush) n_valid = 0;
    else if (!m_valid || ex_ready) begin
      if (model_hazard()) n_valid = 0;
      else begin n_valid = id_valid; n_instr = id_instr; n_pc = id_pc; end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_instr = n_instr; m_pc = n_pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_valid = 0; flush = 0; ex_ready = 0;
    rst = 1;
    #1;
    m_valid = 0;
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst ex_pc/imm", ex_pc | ex_imm, 32'd0);
    chk("rst idx/alu", 32'({ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl}), 32'd0);
    chk("rst ctrl", 32'({ex_alu_src, ex_alu_a_pc, ex_result_src, ex_reg_write, ex_mem_write,
                         ex_mem_read, ex_mem_size, ex_branch, ex_jump, ex_jalr,
                         ex_branch_cond, ex_illegal}), 32'd0);
    #2;
    rst = 0;
    #1;
    chk("post-rst id_ready", 32'(id_ready), 32'd1);
  endtask

  logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                               7'h37, 7'h17, 7'h7F, 7'h0B};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[6:0]   = opc_tab[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0001_2283;
  localparam logic [31:0] ADD   = 32'h0012_8333;
  localparam logic [31:0] BNE   = 32'hFE20_9EE3;
  localparam logic [31:0] ILLEG = 32'h0000_007F;

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // addi x1,x0,5
    apply(1, ADDI, 32'h100, 1, 0); tick();
    apply(0, 0, 0, 1, 0);
    chk("addi valid", 32'(ex_valid), 32'd1);
    chk("addi rd", 32'(ex_rd), 32'd1);
    chk("addi imm", ex_imm, 32'd5);
    chk("addi alu", 32'(ex_alu_ctrl), 32'd0);
    chk("addi src/rw", 32'({ex_alu_src, ex_reg_write}), 32'b11);
    tick();

    // rst asserted while an entry is valid
    apply(1, ADDI, 32'h104, 1, 0); tick();
    do_reset();

    // lw x5,0(x2) then dependent add x6,x5,x1
    apply(1, LW, 32'h200, 1, 0); tick();
    apply(1, ADD, 32'h204, 1, 0);
    chk("lu hazard_stall", 32'(hazard_stall), 32'd1);
    chk("lu id_ready", 32'(id_ready), 32'd0);
    tick();
    apply(1, ADD, 32'h204, 1, 0);
    chk("lu bubble", 32'(ex_valid), 32'd0);
    chk("lu no stall", 32'(hazard_stall), 32'd0);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("lu add valid", 32'(ex_valid), 32'd1);
    chk("lu add alu/rd", 32'({ex_alu_ctrl, ex_rd}), 32'({4'd0, 5'd6}));
    tick();

    // bne x1,x2,-4 then an illegal opcode
    apply(1, BNE, 32'h300, 1, 0); tick();
    apply(1, ILLEG, 32'h304, 1, 0);
    chk("bne branch/cond", 32'({ex_branch, ex_branch_cond}), 32'b1001);
    chk("bne imm", ex_imm, 32'hFFFF_FFFC);
    chk("bne rw/alu", 32'({ex_reg_write, ex_alu_ctrl}), 32'd1);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("ill flag", 32'({ex_valid, ex_illegal}), 32'b11);
    chk("ill enables", 32'({ex_reg_write, ex_mem_write, ex_mem_read}), 32'd0);
    tick();

    // hold under backpressure
    apply(1, ADDI, 32'h400, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, LW, 32'h404, 0, 0);
      chk("hold id_ready", 32'(id_ready), 32'd0);
      chk("hold entry", {ex_valid, ex_rd, ex_imm[25:0]}, {1'b1, 5'd1, 26'd5});
      tick();
    end
    apply(0, 0, 0, 1, 0);
    chk("release id_ready", 32'(id_ready), 32'd1);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("released", 32'(ex_valid), 32'd0);
    tick();

    // flush against a stalled EX entry
    apply(1, ADDI, 32'h500, 1, 0); tick();
    apply(1, ADD, 32'h504, 0, 1);
    chk("flush id_ready", 32'(id_ready), 32'd1);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("flush kills", 32'(ex_valid), 32'd0);
    tick();

    // randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      apply($urandom_range(0, 9) < 8, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
